// File: rtl/memctl_pkg.sv
// +----------------------------------------------------------------------------
// | memctl_pkg
// | Shared FSM state type, default timing and counter width for memctl.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package memctl_pkg;

    localparam int MEMCTL_CNT_W        = 4;
    localparam int MEMCTL_SETUP_DEF    = 1;
    localparam int MEMCTL_RAM_WAIT_DEF = 2;
    localparam int MEMCTL_FL_WAIT_DEF  = 6;
    localparam int MEMCTL_HOLD_DEF     = 1;
    localparam int MEMCTL_TURN_DEF     = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_TURN   = 3'd4
    } memctl_state_t;

endpackage

`default_nettype wire

// File: rtl/memctl_tcnt.sv
// +----------------------------------------------------------------------------
// | memctl_tcnt
// | Loadable down-counter with zero flag timing each memctl state.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module memctl_tcnt
    import memctl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [MEMCTL_CNT_W-1:0] i_load_val,
    input  logic                    i_dec,
    output logic                    o_zero
);

    logic [MEMCTL_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/memctl.sv
// +----------------------------------------------------------------------------
// | memctl
// | Async SRAM / NOR flash strobe sequencer with setup, wait, hold, turnaround.
// | Optional macro MEMCTL_FLASH_WRITE_EN enables strobed flash writes.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module memctl
    import memctl_pkg::*;
#(
    parameter int SETUP    = MEMCTL_SETUP_DEF,
    parameter int RAM_WAIT = MEMCTL_RAM_WAIT_DEF,
    parameter int FL_WAIT  = MEMCTL_FL_WAIT_DEF,
    parameter int HOLD     = MEMCTL_HOLD_DEF,
    parameter int TURN     = MEMCTL_TURN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        sel_fl,
    input  logic [22:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rdy,
    output logic        busy,
    output logic [22:0] ext_addr,
    output logic [15:0] ext_dq_o,
    output logic        ext_dq_oe,
    input  logic [15:0] ext_dq_i,
    output logic        ext_oe_n,
    output logic        ext_we_n,
    output logic        ext_ramcs_n,
    output logic        ext_flcs_n
);

`ifdef MEMCTL_FLASH_WRITE_EN
    localparam bit c_FL_WR_EN = 1'b1;
`else
    localparam bit c_FL_WR_EN = 1'b0;
`endif

    // Counter loads hold (cycles - 1) so the zero flag marks the last cycle
    localparam logic [MEMCTL_CNT_W-1:0] c_SETUP_LD = MEMCTL_CNT_W'(SETUP - 1);
    localparam logic [MEMCTL_CNT_W-1:0] c_RAM_LD   = MEMCTL_CNT_W'(RAM_WAIT - 1);
    localparam logic [MEMCTL_CNT_W-1:0] c_FL_LD    = MEMCTL_CNT_W'(FL_WAIT - 1);
    localparam logic [MEMCTL_CNT_W-1:0] c_HOLD_LD  = MEMCTL_CNT_W'(HOLD - 1);
    localparam logic [MEMCTL_CNT_W-1:0] c_TURN_LD  = MEMCTL_CNT_W'(TURN - 1);
    localparam bit                      c_HAS_TURN = (TURN > 0);

    memctl_state_t           r_state;
    memctl_state_t           w_state_nxt;
    logic                    r_we;
    logic                    r_sel;
    logic                    w_load;
    logic [MEMCTL_CNT_W-1:0] w_load_val;
    logic                    w_dec;
    logic                    w_zero;
    logic                    w_start;
    logic                    w_sample;
    logic                    w_rdy_nxt;
    logic                    w_we;
    logic                    w_sel;
    logic                    w_cs_act;
    logic                    w_acc_act;

    memctl_tcnt u_tcnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        w_start     = 1'b0;
        w_sample    = 1'b0;
        w_rdy_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    // Flash writes without the feature complete as a no-op
                    if (we && sel_fl && !c_FL_WR_EN) begin
                        w_rdy_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_load      = 1'b1;
                        w_load_val  = c_SETUP_LD;
                        w_start     = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (w_zero) begin
                    w_state_nxt = ST_ACCESS;
                    w_load      = 1'b1;
                    w_load_val  = r_sel ? c_FL_LD : c_RAM_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (w_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = c_HOLD_LD;
                    w_sample    = !r_we;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_zero) begin
                    w_rdy_nxt = 1'b1;
                    if (!r_we && c_HAS_TURN) begin
                        w_state_nxt = ST_TURN;
                        w_load      = 1'b1;
                        w_load_val  = c_TURN_LD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_TURN: begin
                if (w_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so strobes are glitch-free
    assign w_we      = (r_state == ST_IDLE) ? we     : r_we;
    assign w_sel     = (r_state == ST_IDLE) ? sel_fl : r_sel;
    assign w_cs_act  = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS) ||
                       (w_state_nxt == ST_HOLD);
    assign w_acc_act = (w_state_nxt == ST_ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_sel       <= 1'b0;
            ext_addr    <= '0;
            ext_dq_o    <= '0;
            ext_dq_oe   <= 1'b0;
            ext_oe_n    <= 1'b1;
            ext_we_n    <= 1'b1;
            ext_ramcs_n <= 1'b1;
            ext_flcs_n  <= 1'b1;
            rdata       <= '0;
            rdy         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ext_ramcs_n <= !(w_cs_act && !w_sel);
            ext_flcs_n  <= !(w_cs_act && w_sel);
            ext_oe_n    <= !(w_acc_act && !w_we);
            ext_we_n    <= !(w_acc_act && w_we);
            ext_dq_oe   <= w_cs_act && w_we;
            rdy         <= w_rdy_nxt;
            busy        <= (w_state_nxt != ST_IDLE);
            if (w_start) begin
                r_we     <= we;
                r_sel    <= sel_fl;
                ext_addr <= addr;
                ext_dq_o <= wdata;
            end
            if (w_sample) begin
                rdata <= ext_dq_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memctl.sv
// +----------------------------------------------------------------------------
// | tb_memctl
// | Randomized scoreboard bench for memctl against a timing-window model.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_memctl;

    localparam int S  = 1;
    localparam int RW = 2;
    localparam int FW = 6;
    localparam int H  = 1;
    localparam int T  = 1;
`ifdef MEMCTL_FLASH_WRITE_EN
    localparam bit FL_WR = 1'b1;
`else
    localparam bit FL_WR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic        sel_fl;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;
    logic        busy;
    logic [22:0] ext_addr;
    logic [15:0] ext_dq_o;
    logic        ext_dq_oe;
    logic [15:0] ext_dq_i;
    logic        ext_oe_n;
    logic        ext_we_n;
    logic        ext_ramcs_n;
    logic        ext_flcs_n;

    memctl #(.SETUP(S), .RAM_WAIT(RW), .FL_WAIT(FW), .HOLD(H), .TURN(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .we          (we),
        .sel_fl      (sel_fl),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdy         (rdy),
        .busy        (busy),
        .ext_addr    (ext_addr),
        .ext_dq_o    (ext_dq_o),
        .ext_dq_oe   (ext_dq_oe),
        .ext_dq_i    (ext_dq_i),
        .ext_oe_n    (ext_oe_n),
        .ext_we_n    (ext_we_n),
        .ext_ramcs_n (ext_ramcs_n),
        .ext_flcs_n  (ext_flcs_n)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Model of the most recently accepted transaction as cycle windows
    bit          t_strobe = 0;
    logic        t_we = 0;
    logic        t_sel = 0;
    logic [22:0] t_addr = 0;
    logic [15:0] t_wdata = 0;
    int          t_c = 0, t_end_cs = 0, acc_lo = 0, acc_hi = 0;
    int          busy_lo = 1, busy_hi = 0, free = 0;
    logic [15:0] last_rd = 0, prev_rd = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] dqf(input int k);
        logic [31:0] x;
        x = 32'(k) * 32'h9E3779B1;
        return x[31:16] ^ 16'hA5C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        ext_dq_i = dqf(0);
        forever begin
            @(posedge clk);
            cyc++;
            #1 ext_dq_i = dqf(cyc);
        end
    end

    always @(negedge clk) begin
        logic       ics, iacc;
        logic [5:0] act6, exp6;
        exp_t       e;
        if (cyc >= 1) begin
            ics  = t_strobe && (cyc > t_c) && (cyc <= t_end_cs);
            iacc = t_strobe && (cyc >= acc_lo) && (cyc <= acc_hi);
            exp6 = {!(ics && !t_sel), !(ics && t_sel), !(iacc && !t_we), !(iacc && t_we),
                    ics && t_we, (cyc >= busy_lo) && (cyc <= busy_hi)};
            act6 = {ext_ramcs_n, ext_flcs_n, ext_oe_n, ext_we_n, ext_dq_oe, busy};
            chk("strobes{ramcs_n,flcs_n,oe_n,we_n,dq_oe,busy}", 32'(act6), 32'(exp6));
            if (ics) chk("ext_addr", 32'(ext_addr), 32'(t_addr));
            if (ics && t_we) chk("ext_dq_o", 32'(ext_dq_o), 32'(t_wdata));
            if (rdy) begin
                if (q.size() == 0) begin
                    chk("rdy_spurious", 32'(rdy), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("rdy_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rdata", 32'(rdata), 32'(e.data));
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                chk("rdy_missing", 32'(rdy), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input logic w, input logic s, input logic [22:0] a,
                          input logic [15:0] d);
        int c, wt, rc;
        exp_t e;
        c  = cyc;
        wt = s ? FW : RW;
        if (w && s && !FL_WR) begin
            e.cyc = c + 1; e.data = last_rd;
            q.push_back(e);
            free     = c + 1;
            t_strobe = 0;
            busy_lo  = 1;
            busy_hi  = 0;
        end else begin
            t_strobe = 1; t_c = c; t_we = w; t_sel = s; t_addr = a; t_wdata = d;
            t_end_cs = c + S + wt + H;
            acc_lo   = c + S + 1;
            acc_hi   = c + S + wt;
            rc       = c + S + wt + H + 1;
            if (!w) begin
                prev_rd = last_rd;
                last_rd = dqf(c + S + wt);
            end
            e.cyc = rc; e.data = last_rd;
            q.push_back(e);
            free    = (w || T == 0) ? rc : rc + T;
            busy_lo = c + 1;
            busy_hi = free - 1;
        end
    endtask

    task automatic issue(input logic w, input logic s, input logic [22:0] a,
                         input logic [15:0] d, output bit acc);
        req = 1'b1; we = w; sel_fl = s; addr = a; wdata = d;
        acc = (cyc >= free);
        if (acc) accept(w, s, a, d);
        step();
        req = 1'b0;
    endtask

    task automatic wait_free();
        while (cyc < free) step();
    endtask

    // Reset during cycle k: outputs of cycle k unchanged, idle afterwards
    task automatic abort_now();
        int k;
        k = cyc;
        rst = 1'b1;
        if (t_end_cs > k) t_end_cs = k;
        if (acc_hi > k) acc_hi = k;
        if (busy_hi > k) busy_hi = k;
        last_rd = prev_rd;
        q.delete();
        free = k + 1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        bit acc;
        rst = 1'b1; req = 1'b0; we = 1'b0; sel_fl = 1'b0; addr = '0; wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_ext_addr", 32'(ext_addr), 32'd0);
        chk("reset_ext_dq_o", 32'(ext_dq_o), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_rdy", 32'(rdy), 32'd0);
        step();

        // Abort a read in its second ACCESS cycle
        issue(1'b0, 1'b0, 23'h000100, 16'h0000, acc);
        while (cyc < acc_lo + 1) step();
        abort_now();
        repeat (4) step();
        chk("abort_rdata", 32'(rdata), 32'd0);

        issue(1'b0, 1'b0, 23'h000100, 16'h0000, acc);
        wait_free();
        issue(1'b1, 1'b0, 23'h7FFFFF, 16'h1234, acc);
        wait_free();
        issue(1'b0, 1'b1, 23'h0ABCDE, 16'h0000, acc);
        wait_free();
        issue(1'b0, 1'b0, 23'h02AAAA, 16'h0000, acc);
        for (int i = 0; i < 20; i++) begin
            issue(1'b1, 1'b0, 23'h055555, 16'hBEEF, acc);
            if (acc) break;
        end
        wait_free();
        issue(1'b1, 1'b1, 23'h001234, 16'hCAFE, acc);
        wait_free();
        issue(1'b1, 1'b1, 23'h001236, 16'hF00D, acc);
        issue(1'b0, 1'b0, 23'h000777, 16'h0000, acc);
        wait_free();

        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 3)) step();
            issue(1'($urandom()), 1'($urandom()), 23'($urandom()), 16'($urandom()), acc);
        end
        wait_free();
        repeat (5) step();
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
